// File: rtl/rdm_llr_join_packer.sv
// rdm_llr_join_packer: packs narrow demapper LLR beats (1..8 bytes) into
// variable-length, LSB-aligned groups for the rate de-matching FIFO Join port.
// Each code block consumes exactly E LLRs and then flushes any partial group.
module rdm_llr_join_packer #(
  parameter int GROUP_BYTES = 16
) (
  input  logic         i_core_clk,
  input  logic         i_rx_rstn,
  input  logic         i_cb_start,
  input  logic [15:0]  i_cb_e,
  input  logic         i_llr_valid,
  output logic         o_llr_ready,
  input  logic [3:0]   i_llr_num,
  input  logic [63:0]  i_llr_data,
  output logic         JoinEnable,
  input  logic         JoinPermit,
  output logic [4:0]   JoinAmount,
  output logic [255:0] JoinData,
  output logic         o_cb_done,
  output logic         o_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_DONE} state_t;

  localparam logic [5:0] GB = 6'(GROUP_BYTES);

  state_t         state_q, state_d;
  logic [255:0]   acc_q, acc_d;
  logic [5:0]     acc_cnt_q, acc_cnt_d;
  logic [15:0]    rem_q, rem_d;
  logic           overrun_q, overrun_d;

  logic           llr_ready;
  logic           beat_fire;
  logic [3:0]     take;
  logic [5:0]     new_cnt;
  logic [15:0]    new_rem;
  logic [255:0]   beat_shifted;

  // Bytes actually consumed from a beat: never more than 8 (bus width) nor
  // more than the LLRs still owed to this code block.
  function automatic logic [3:0] take_cnt(input logic [3:0] num, input logic [15:0] rem);
    logic [3:0] n;
    n = (num > 4'd8) ? 4'd8 : num;
    if ({12'b0, n} > rem) return rem[3:0];
    return n;
  endfunction

  // Keeps only the lowest 'take' bytes of a beat so dropped excess bytes
  // can never leak into the accumulator.
  function automatic logic [63:0] byte_mask(input logic [3:0] tk);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < tk) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Outputs decode from registers only; no path from JoinPermit or i_llr_valid.
  assign llr_ready   = (state_q == S_FILL) && (rem_q != 16'd0) && (acc_cnt_q < GB);
  assign o_llr_ready = llr_ready;
  assign JoinEnable  = (state_q == S_EMIT);
  assign JoinAmount  = (state_q == S_EMIT) ? 5'(acc_cnt_q - 6'd1) : 5'd0;
  assign JoinData    = (state_q == S_EMIT) ? acc_q : '0;
  assign o_cb_done   = (state_q == S_DONE);
  assign o_overrun   = overrun_q;

  // Next-state, accumulator append and group hand-off decisions.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    rem_d        = rem_q;
    overrun_d    = 1'b0;
    beat_fire    = i_llr_valid && llr_ready;
    take         = take_cnt(i_llr_num, rem_q);
    new_cnt      = acc_cnt_q + {2'b0, take};
    new_rem      = rem_q - {12'b0, take};
    beat_shifted = {192'b0, (i_llr_data & byte_mask(take))} << {acc_cnt_q, 3'b000};
    case (state_q)
      S_IDLE: begin
        if (i_cb_start) begin
          rem_d     = i_cb_e;
          acc_d     = '0;
          acc_cnt_d = '0;
          state_d   = (i_cb_e != 16'd0) ? S_FILL : S_DONE;
        end
      end
      S_FILL: begin
        if (beat_fire) begin
          acc_d     = acc_q | beat_shifted;
          acc_cnt_d = new_cnt;
          rem_d     = new_rem;
          overrun_d = ({12'b0, i_llr_num} > rem_q);
          // Close the group on threshold, or flush the tail once E is exhausted.
          if ((new_cnt >= GB) || ((new_rem == 16'd0) && (new_cnt != 6'd0)))
            state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (JoinPermit) begin
          acc_d     = '0;
          acc_cnt_d = '0;
          state_d   = (rem_q == 16'd0) ? S_DONE : S_FILL;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial group.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      rem_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      rem_q     <= rem_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_rdm_llr_join_packer.sv
// Bench for rdm_llr_join_packer: directed code blocks from the test plan plus
// randomized blocks, checked against a byte-queue reference model.
module tb_rdm_llr_join_packer;

  localparam int GB = 16;

  logic         clk;
  logic         rst_n;
  logic         cb_start;
  logic [15:0]  cb_e;
  logic         llr_valid;
  logic         llr_ready;
  logic [3:0]   llr_num;
  logic [63:0]  llr_data;
  logic         join_en;
  logic         join_permit;
  logic [4:0]   join_amt;
  logic [255:0] join_data;
  logic         cb_done;
  logic         overrun;

  rdm_llr_join_packer #(.GROUP_BYTES(GB)) dut (
    .i_core_clk (clk),
    .i_rx_rstn  (rst_n),
    .i_cb_start (cb_start),
    .i_cb_e     (cb_e),
    .i_llr_valid(llr_valid),
    .o_llr_ready(llr_ready),
    .i_llr_num  (llr_num),
    .i_llr_data (llr_data),
    .JoinEnable (join_en),
    .JoinPermit (join_permit),
    .JoinAmount (join_amt),
    .JoinData   (join_data),
    .o_cb_done  (cb_done),
    .o_overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   amt;
    logic [255:0] data;
  } grp_t;

  grp_t        exp_q[$];
  int          bt_num[$];
  logic [63:0] bt_data[$];
  int          dir_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int exp_ovr = 0;
  int perm_mode = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // JoinPermit pattern generator
  initial begin
    int st;
    st = 0;
    join_permit = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (perm_mode)
        0: join_permit = 1'b1;
        1: join_permit = ($urandom_range(0, 2) != 0);
        2: begin
          if (join_en) begin
            join_permit = (st >= 10);
            st++;
          end else begin
            st = 0;
            join_permit = 1'b0;
          end
        end
        default: join_permit = 1'b0;
      endcase
    end
  end

  // Output monitor: group transfers, stall stability, pulse counting
  initial begin
    bit           hold;
    logic [4:0]   h_amt;
    logic [255:0] h_data;
    grp_t         g;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hold = 1'b0;
        continue;
      end
      if (overrun) ovr_cnt++;
      if (cb_done) done_cnt++;
      if (hold) begin
        chk("stall_en", join_en, 1'b1);
        chk("stall_amt", join_amt, h_amt);
        chk("stall_data", join_data, h_data);
      end
      hold = 1'b0;
      if (join_en) begin
        chk("ready_in_emit", llr_ready, 1'b0);
        if (join_permit) begin
          if (exp_q.size() == 0) begin
            chk("extra_group", join_en, 1'b0);
          end else begin
            g = exp_q.pop_front();
            chk("grp_amt", join_amt, g.amt);
            chk("grp_data", join_data, g.data);
          end
        end else begin
          hold   = 1'b1;
          h_amt  = join_amt;
          h_data = join_data;
        end
      end
    end
  end

  // Build beats and the expected group list from the block's rules
  task automatic build_block(input int e, input bit seq);
    int          rem, num, take, idx;
    logic [7:0]  sv;
    logic [7:0]  cur[$];
    logic [63:0] d;
    grp_t        g;
    rem = e; idx = 0; sv = 8'd0; exp_ovr = 0;
    bt_num.delete(); bt_data.delete(); cur.delete();
    while (rem > 0) begin
      num = (idx < dir_q.size()) ? dir_q[idx] : $urandom_range(0, 8);
      idx++;
      take = (num < rem) ? num : rem;
      d = {$urandom, $urandom};
      for (int i = 0; i < take; i++) begin
        if (seq) begin
          d[i*8 +: 8] = sv;
          sv++;
        end
        cur.push_back(d[i*8 +: 8]);
      end
      if (num > rem) exp_ovr++;
      rem -= take;
      bt_num.push_back(num);
      bt_data.push_back(d);
      if (cur.size() >= GB || (rem == 0 && cur.size() > 0)) begin
        g.amt  = 5'(cur.size() - 1);
        g.data = '0;
        for (int i = 0; i < cur.size(); i++) g.data[i*8 +: 8] = cur[i];
        exp_q.push_back(g);
        cur.delete();
      end
    end
    dir_q.delete();
  endtask

  task automatic start_block(input int e);
    @(posedge clk); #1;
    cb_start = 1'b1;
    cb_e     = 16'(e);
    @(posedge clk); #1;
    cb_start = 1'b0;
  endtask

  task automatic drive_beats(input bit gaps);
    bit ok;
    for (int b = 0; b < bt_num.size(); b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        llr_valid = 1'b0;
        @(posedge clk); #1;
      end
      llr_valid = 1'b1;
      llr_num   = 4'(bt_num[b]);
      llr_data  = bt_data[b];
      ok = 1'b0;
      for (int w = 0; w < 300 && !ok; w++) begin
        @(negedge clk);
        ok = llr_ready;
        @(posedge clk); #1;
      end
      if (!ok) begin
        chk("beat_accept", llr_ready, 1'b1);
        llr_valid = 1'b0;
        return;
      end
    end
    llr_valid = 1'b0;
    llr_num   = 4'd0;
  endtask

  task automatic run_block(input int e, input bit seq, input int pmode, input bit gaps);
    perm_mode = pmode;
    done_cnt  = 0;
    ovr_cnt   = 0;
    build_block(e, seq);
    start_block(e);
    if (e == 0) chk("e0_done", cb_done, 1'b1);
    drive_beats(gaps);
    for (int w = 0; w < 2000 && done_cnt == 0; w++) @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("cb_done_cnt", done_cnt, 1);
    chk("overrun_cnt", ovr_cnt, exp_ovr);
    chk("groups_left", exp_q.size(), 0);
  endtask

  initial begin
    bit got;
    rst_n = 1'b0; cb_start = 1'b0; cb_e = '0;
    llr_valid = 1'b0; llr_num = '0; llr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", llr_ready, 1'b0);
    chk("rst_en", join_en, 1'b0);
    chk("rst_amt", join_amt, 5'd0);
    chk("rst_data", join_data, 256'd0);
    chk("rst_done", cb_done, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // E=32, 4-byte beats, sequential bytes
    for (int i = 0; i < 8; i++) dir_q.push_back(4);
    run_block(32, 1'b1, 0, 1'b0);
    // E=20, beats 8,8,4
    dir_q.push_back(8); dir_q.push_back(8); dir_q.push_back(4);
    run_block(20, 1'b1, 0, 1'b0);
    // E=30, 7-byte beats -> groups of 21 and 9
    for (int i = 0; i < 5; i++) dir_q.push_back(7);
    run_block(30, 1'b1, 0, 1'b0);
    // Long stall in EMIT
    for (int i = 0; i < 6; i++) dir_q.push_back(8);
    run_block(40, 1'b1, 2, 1'b0);
    // E=5 with an 8-LLR beat -> overrun
    dir_q.push_back(8);
    run_block(5, 1'b1, 0, 1'b0);
    // E=0
    run_block(0, 1'b1, 0, 1'b0);

    // Reset while holding a 12-byte group in EMIT
    mon_en = 1'b0;
    perm_mode = 3;
    exp_q.delete();
    start_block(12);
    for (int b = 0; b < 3; b++) begin
      llr_valid = 1'b1; llr_num = 4'd4; llr_data = {$urandom, $urandom};
      got = 1'b0;
      for (int w = 0; w < 50 && !got; w++) begin
        @(negedge clk); got = llr_ready;
        @(posedge clk); #1;
      end
    end
    llr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_en", join_en, 1'b1);
    chk("pre_rst_amt", join_amt, 5'd11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", join_en, 1'b0);
    chk("mid_rst_amt", join_amt, 5'd0);
    chk("mid_rst_data", join_data, 256'd0);
    chk("mid_rst_ready", llr_ready, 1'b0);
    chk("mid_rst_done", cb_done, 1'b0);
    chk("mid_rst_ovr", overrun, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_block(16, 1'b1, 0, 1'b0);

    // Randomized blocks
    for (int k = 0; k < 25; k++)
      run_block($urandom_range(1, 120), 1'b0, $urandom_range(0, 1), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
